// File: rtl/lilme_v2.sv
// lilme_v2: signed integer matrix engine (C = A*B or C += A*B) with an opcode/Busy command port.
// Build macro LILME_SAT_EN: saturating accumulation and sticky ovf; undefined wraps modulo 2^RW.
module lilme_v2 #(
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int INNER = 4,
  parameter int COLS  = 4,
  localparam int RW   = 2*DW + $clog2(INNER)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    ME_opcode,
  input  logic [DW-1:0] Data_in,
  input  logic          in_valid,
  output logic          Busy,
  output logic [RW-1:0] Data_out,
  output logic          out_valid,
  output logic          done,
  output logic          err,
  output logic          ovf
);

  localparam int NA  = ROWS * INNER;
  localparam int NB  = INNER * COLS;
  localparam int NC  = ROWS * COLS;
  localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BAW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CAW = (NC > 1) ? $clog2(NC) : 1;
  localparam int LW  = (NA > NB) ? AAW : BAW;
  localparam int IW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int JW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW  = (INNER > 1) ? $clog2(INNER) : 1;

  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_LOAD_A = 3'b010;
  localparam logic [2:0] OP_LOAD_B = 3'b011;
  localparam logic [2:0] OP_RSVD   = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_MAC    = 3'b110;
  localparam logic [2:0] OP_READ   = 3'b111;

  localparam logic [LW-1:0]  A_LAST = LW'(NA - 1);
  localparam logic [LW-1:0]  B_LAST = LW'(NB - 1);
  localparam logic [IW-1:0]  I_LAST = IW'(ROWS - 1);
  localparam logic [JW-1:0]  J_LAST = JW'(COLS - 1);
  localparam logic [KW-1:0]  K_LAST = KW'(INNER - 1);
  localparam logic [CAW-1:0] C_LAST = CAW'(NC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_READ
  } state_t;

  state_t state_reg, state_next;

  // A and B are never reset: their contents survive reset and CLEAR.
  logic signed [DW-1:0] a_mem [NA];
  logic signed [DW-1:0] b_mem [NB];
  logic signed [RW-1:0] c_mem [NC];

  logic [LW-1:0]        ld_reg;
  logic [IW-1:0]        i_reg;
  logic [JW-1:0]        j_reg;
  logic [KW-1:0]        k_reg;
  logic [CAW-1:0]       rd_reg;
  logic signed [RW-1:0] acc_reg;
  logic                 mode_mac_reg;
  logic [RW-1:0]        data_out_reg;
  logic                 out_valid_reg;
  logic                 done_reg;
  logic                 err_reg;
  logic                 ovf_reg;

  logic [AAW-1:0]         a_idx;
  logic [BAW-1:0]         b_idx;
  logic [CAW-1:0]         c_idx;
  logic [CAW-1:0]         rd_next;
  logic signed [2*DW-1:0] prod;
  logic signed [RW-1:0]   prod_ext;
  logic signed [RW-1:0]   base;
  logic signed [RW-1:0]   sum;
  logic                   clamp;
  logic                   last_mac;
  logic                   rd_last;

`ifdef LILME_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {1'b1, {(RW-1){1'b0}}};
  logic [RW:0] sum_wide;
`endif

  assign Busy      = (state_reg != S_IDLE);
  assign Data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign ovf       = ovf_reg;

  assign last_mac = (i_reg == I_LAST) && (j_reg == J_LAST) && (k_reg == K_LAST);
  assign rd_last  = (rd_reg == C_LAST);
  assign rd_next  = rd_reg + 1'b1;

  // One multiply-accumulate step: k innermost, partial sum seeded at k = 0.
  always_comb begin
    a_idx    = AAW'(int'(i_reg) * INNER + int'(k_reg));
    b_idx    = BAW'(int'(k_reg) * COLS + int'(j_reg));
    c_idx    = CAW'(int'(i_reg) * COLS + int'(j_reg));
    prod     = a_mem[a_idx] * b_mem[b_idx];
    prod_ext = RW'(prod);
    base     = acc_reg;
    if (k_reg == '0) begin
      base = mode_mac_reg ? c_mem[c_idx] : '0;
    end
`ifdef LILME_SAT_EN
    sum_wide = {base[RW-1], base} + {prod_ext[RW-1], prod_ext};
    clamp    = sum_wide[RW] ^ sum_wide[RW-1];
    if (clamp) begin
      sum = sum_wide[RW] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = sum_wide[RW-1:0];
    end
`else
    clamp = 1'b0;
    sum   = base + prod_ext;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        case (ME_opcode)
          OP_LOAD_A:      state_next = S_LOAD_A;
          OP_LOAD_B:      state_next = S_LOAD_B;
          OP_MUL, OP_MAC: state_next = S_COMPUTE;
          OP_READ:        state_next = S_READ;
          default:        state_next = S_IDLE;
        endcase
      end
      S_LOAD_A:  if (in_valid && ld_reg == A_LAST) state_next = S_IDLE;
      S_LOAD_B:  if (in_valid && ld_reg == B_LAST) state_next = S_IDLE;
      S_COMPUTE: if (last_mac) state_next = S_IDLE;
      S_READ:    if (rd_last) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      if (state_reg == S_LOAD_A) a_mem[AAW'(ld_reg)] <= Data_in;
      if (state_reg == S_LOAD_B) b_mem[BAW'(ld_reg)] <= Data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_reg        <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      rd_reg        <= '0;
      acc_reg       <= '0;
      mode_mac_reg  <= 1'b0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      for (int n = 0; n < NC; n++) c_mem[n] <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          case (ME_opcode)
            OP_CLEAR: begin
              ovf_reg <= 1'b0;
              for (int n = 0; n < NC; n++) c_mem[n] <= '0;
            end
            OP_RSVD: err_reg <= 1'b1;
            OP_LOAD_A, OP_LOAD_B: ld_reg <= '0;
            OP_MUL, OP_MAC: begin
              mode_mac_reg <= (ME_opcode == OP_MAC);
              i_reg        <= '0;
              j_reg        <= '0;
              k_reg        <= '0;
            end
            OP_READ: begin
              data_out_reg  <= c_mem[0];
              out_valid_reg <= 1'b1;
              rd_reg        <= '0;
            end
            default: ;
          endcase
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_valid) ld_reg <= ld_reg + 1'b1;
        end
        S_COMPUTE: begin
          if (clamp) ovf_reg <= 1'b1;
          if (k_reg == K_LAST) begin
            c_mem[c_idx] <= sum;
            k_reg        <= '0;
            if (j_reg == J_LAST) begin
              j_reg <= '0;
              i_reg <= i_reg + 1'b1;
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end else begin
            acc_reg <= sum;
            k_reg   <= k_reg + 1'b1;
          end
          done_reg <= last_mac;
        end
        S_READ: begin
          if (rd_last) begin
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
          end else begin
            rd_reg       <= rd_next;
            data_out_reg <= c_mem[rd_next];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lilme_v2.sv
// Self-checking bench for lilme_v2 (2x2x2, DW=8) against a behavioural matrix model.
module tb_lilme_v2;

  localparam int DW    = 8;
  localparam int ROWS  = 2;
  localparam int INNER = 2;
  localparam int COLS  = 2;
  localparam int RW    = 17;
  localparam int NMAC  = ROWS * COLS * INNER;
  localparam longint MAXV = (64'sd1 <<< (RW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (RW-1));

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    ME_opcode;
  logic [DW-1:0] Data_in;
  logic          in_valid;
  logic          Busy;
  logic [RW-1:0] Data_out;
  logic          out_valid;
  logic          done;
  logic          err;
  logic          ovf;

  lilme_v2 #(.DW(DW), .ROWS(ROWS), .INNER(INNER), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .ME_opcode(ME_opcode), .Data_in(Data_in),
    .in_valid(in_valid), .Busy(Busy), .Data_out(Data_out), .out_valid(out_valid),
    .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  longint a_m [ROWS][INNER];
  longint b_m [INNER][COLS];
  longint c_m [ROWS][COLS];
  bit     ovf_m;
  longint wv [4];

  // Reduce an exact sum to the representable result of one accumulate step.
  function automatic longint step(longint v);
    longint m;
`ifdef LILME_SAT_EN
    m = v;
    if (v > MAXV) begin m = MAXV; ovf_m = 1'b1; end
    if (v < MINV) begin m = MINV; ovf_m = 1'b1; end
`else
    m = v & ((64'sd1 <<< RW) - 1);
    if (m > MAXV) m = m - (64'sd1 <<< RW);
`endif
    return m;
  endfunction

  function automatic void model_compute(bit mac);
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        longint s;
        s = mac ? c_m[i][j] : 64'sd0;
        for (int k = 0; k < INNER; k++) s = step(s + a_m[i][k] * b_m[k][j]);
        c_m[i][j] = s;
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) c_m[i][j] = 0;
    ovf_m = 1'b0;
  endfunction

  task automatic issue(input logic [2:0] op);
    ME_opcode = op;
    @(negedge clk);
    ME_opcode = 3'b000;
  endtask

  task automatic load_mat(input bit is_b, input bit gaps);
    issue(is_b ? 3'b011 : 3'b010);
    for (int n = 0; n < 4; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          Data_in  = DW'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      Data_in  = DW'(wv[n]);
      @(negedge clk);
      in_valid = 1'b0;
      if (is_b) b_m[n / COLS][n % COLS] = wv[n];
      else      a_m[n / INNER][n % INNER] = wv[n];
    end
    n_vec++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_busy_fall: Busy=%b want 0 (is_b=%0d)", Busy, is_b);
    end
  endtask

  task automatic run_compute(input bit mac, input bit junk);
    int cyc;
    bit seen;
    issue(mac ? 3'b110 : 3'b101);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_vec++;
        if (Busy !== 1'b1) begin
          n_err++;
          $display("FAIL compute_busy: cycle %0d Busy=%b want 1", cyc, Busy);
        end
        ME_opcode = (junk && cyc < 5) ? 3'($urandom_range(1, 7)) : 3'b000;
        in_valid  = junk ? 1'($urandom) : 1'b0;
        Data_in   = DW'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    ME_opcode = 3'b000;
    in_valid  = 1'b0;
    n_vec++;
    if (!seen || cyc != NMAC) begin
      n_err++;
      $display("FAIL done_latency: seen=%0d after %0d cycles want %0d", seen, cyc, NMAC);
    end
    n_vec++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_with_done: Busy=%b want 0", Busy);
    end
    model_compute(mac);
  endtask

  task automatic read_c(input string tag);
    logic [RW-1:0] e;
    issue(3'b111);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_width: done=%b want 0", tag, done);
    end
    for (int n = 0; n < ROWS * COLS; n++) begin
      e = RW'(c_m[n / COLS][n % COLS]);
      n_vec++;
      if (out_valid !== 1'b1 || Busy !== 1'b1 || Data_out !== e) begin
        n_err++;
        $display("FAIL %s_c%0d: valid=%b busy=%b data=%0d want valid=1 busy=1 data=%0d",
                 tag, n, out_valid, Busy, $signed(Data_out), $signed(e));
      end
      @(negedge clk);
    end
    n_vec++;
    if (out_valid !== 1'b0 || Busy !== 1'b0 || Data_out !== '0) begin
      n_err++;
      $display("FAIL %s_end: valid=%b busy=%b data=%0d want 0 0 0", tag, out_valid, Busy, Data_out);
    end
    n_vec++;
    if (ovf !== ovf_m) begin
      n_err++;
      $display("FAIL %s_ovf: ovf=%b want %b", tag, ovf, ovf_m);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    ME_opcode = 3'b000;
    Data_in   = '0;
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (Busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_vec++; if (Data_out !== '0)    begin n_err++; $display("FAIL reset_data: got %0d want 0", Data_out); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0)       begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (ovf !== 1'b0)       begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_mul;
    issue(3'b001);
    model_clear();
    n_vec++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL clear_busy: got %b want 0", Busy); end
    wv = '{1, 2, 3, 4};
    load_mat(1'b0, 1'b0);
    wv = '{5, 6, 7, 8};
    load_mat(1'b1, 1'b0);
    run_compute(1'b0, 1'b0);
    read_c("mul");
  endtask

  task automatic test_mac;
    run_compute(1'b1, 1'b0);
    read_c("mac");
    for (int n = 0; n < 4; n++) wv[n] = longint'($urandom_range(0, 255)) - 128;
    load_mat(1'b0, 1'b1);
    run_compute(1'b0, 1'b0);
    read_c("gap_load");
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < 4; n++) wv[n] = longint'($urandom_range(0, 255)) - 128;
      load_mat(1'b0, 1'($urandom));
      for (int n = 0; n < 4; n++) wv[n] = longint'($urandom_range(0, 255)) - 128;
      load_mat(1'b1, 1'($urandom));
      run_compute(1'($urandom), 1'b0);
      read_c("rand");
    end
  endtask

  task automatic test_saturation;
    wv = '{-128, -128, -128, -128};
    load_mat(1'b0, 1'b0);
    load_mat(1'b1, 1'b0);
    issue(3'b001);
    model_clear();
    run_compute(1'b1, 1'b0);
    run_compute(1'b1, 1'b0);
    read_c("sat");
    issue(3'b001);
    model_clear();
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL clear_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_illegal;
    issue(3'b100);
    n_vec++;
    if (err !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL rsvd_err: err=%b busy=%b want 1 0", err, Busy);
    end
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL rsvd_err_width: err=%b busy=%b want 0 0", err, Busy);
    end
    run_compute(1'b0, 1'b1);
    read_c("ignored_ops");
  endtask

  task automatic test_reset_mid;
    bit seen;
    for (int n = 0; n < 4; n++) wv[n] = longint'($urandom_range(0, 255)) - 128;
    load_mat(1'b1, 1'b0);
    issue(3'b101);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n_vec++;
    if (Busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_busy: busy=%b done=%b want 0 0", Busy, done);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_done: done pulsed=%b want 0", seen); end
    read_c("midreset");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 4; n++) wv[n] = longint'($urandom_range(0, 255)) - 128;
    load_mat(1'b0, 1'b0);
    load_mat(1'b1, 1'b0);
    run_compute(1'b1, 1'b0);
    read_c("b2b_first");
    read_c("b2b_second");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mac();
    test_random();
    test_saturation();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
